l1c_axi_bridge: RTL
===================

L1C_AXI_BRIDGE -- requirements
Module: l1c_axi_bridge
Interface
REQ-001 SHALL have no parameters; bus width 32, read burst 4 beats INCR, write single beat, fixed.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rstn  in  1  reset, asynchronous assert, active-low.
REQ-004 D_req  in  1  cache request, held high by cache until its completion.
REQ-005 D_addr  in  32  request address (line-aligned for reads, word address for writes).
REQ-006 D_write  in  1  1 = write request, 0 = line-fill read.
REQ-007 D_in  in  32  write data.
REQ-008 D_type  in  4  active-low byte write enables (4'hf = no byte written).
REQ-009 D_out  out  32  read beat data to cache.
REQ-010 rvalid_o  out  1  read beat valid to cache.
REQ-011 rready_o  out  1  read beat ready to cache; cache counts a beat when rvalid_o & rready_o.
REQ-012 wdone_o  out  1  one-cycle write-complete pulse to cache.
REQ-013 ARADDR  out  32  read burst start address.
REQ-014 ARLEN  out  4  burst length minus one.
REQ-015 ARVALID  out  1  AR valid.
REQ-016 ARREADY  in  1  AR ready.
REQ-017 RDATA  in  32  read data.
REQ-018 RLAST  in  1  last read beat.
REQ-019 RVALID  in  1  R valid.
REQ-020 RREADY  out  1  R ready.
REQ-021 AWADDR  out  32  write address.
REQ-022 AWVALID  out  1  AW valid.
REQ-023 AWREADY  in  1  AW ready.
REQ-024 WDATA  out  32  write data.
REQ-025 WSTRB  out  4  active-high byte strobes.
REQ-026 WLAST  out  1  constant 1 (single-beat writes).
REQ-027 WVALID  out  1  W valid.
REQ-028 WREADY  in  1  W ready.
REQ-029 BVALID  in  1  B valid.
REQ-030 BREADY  out  1  B ready.
Function
REQ-031 FSM states SHALL be IDLE, AR, RD, WR (AW+W), RESP (B), DONE.
REQ-032 IDLE: D_req & ~D_write -> AR, registering ARADDR = {D_addr[31:4],4'h0}, ARLEN = 4'd3; D_req & D_write -> WR, registering AWADDR = D_addr, WDATA = D_in, WSTRB = ~D_type.
REQ-033 AR: ARVALID = 1, held with stable ARADDR/ARLEN until ARREADY; same-cycle handshake -> RD next cycle.
REQ-034 RD: RREADY = 1; rvalid_o = RVALID, rready_o = RREADY, D_out = RDATA combinationally (zero-latency pass-through); RVALID & RLAST -> DONE.
REQ-035 Outside RD, rvalid_o, rready_o SHALL be 0 and D_out SHALL be 32'd0.
REQ-036 WR: AWVALID and WVALID asserted together on entry; each deasserts independently after its own handshake; both completed (any order, or same cycle) -> RESP.
REQ-037 RESP: BREADY = 1; wdone_o = BVALID (combinational, exactly one cycle); BVALID -> DONE.
REQ-038 DONE: one cycle, no outputs asserted, D_req ignored, -> IDLE; prevents re-issue from a D_req still high.
REQ-039 D_req, D_addr, D_write, D_in, D_type SHALL be ignored in every state except IDLE.
REQ-040 RRESP/BRESP codes are not observed; every completed transaction counts as success.
REQ-041 Beat counter (2-bit) SHALL count RD handshakes; RLAST not on fourth beat is a protocol error flagged by assertion only, exit still on RLAST.
Reset
REQ-042 rstn low SHALL immediately force IDLE, all VALID/READY/wdone_o low, ARADDR/AWADDR/WDATA 0, WSTRB 0, ARLEN 0, counter 0; a burst in flight is abandoned.
Verification
REQ-043 Read D_addr=32'h0000_1234, ARREADY after 2 cycles, 4 beats with RLAST on the fourth -> ARADDR=32'h0000_1230, ARLEN=3, four rvalid_o&rready_o pulses mirroring RDATA, then DONE, then IDLE.
REQ-044 Write D_addr=32'h0000_2008, D_in=32'hDEAD_BEEF, D_type=4'b1100, WREADY 3 cycles before AWREADY -> WSTRB=4'b0011, WVALID drops first, one wdone_o pulse on BVALID.
REQ-045 RVALID gapped (beat, 2 idle, beat, beat, beat) -> rvalid_o follows RVALID exactly, no extra beats.
REQ-046 D_req held high through DONE -> no second AR/AW issued until IDLE.
REQ-047 rstn low during second read beat -> all outputs at reset values asynchronously; next D_req restarts cleanly from IDLE.

Source files
------------

// File: rtl/l1c_axi_bridge.sv
// ============================================================================
// Module   : l1c_axi_bridge
// Purpose  : Bridges a simple L1 cache miss/write port onto a 32-bit AXI
//            master. Reads are 4-beat INCR line fills; writes are single beat.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   D_req/D_addr/D_write      cache request (sampled only in IDLE)
//   D_in/D_type               write data, active-low byte enables
//   D_out/rvalid_o/rready_o   read beat pass-through to cache
//   wdone_o                   one-cycle write-complete pulse
//   AR*/R*/AW*/W*/B*          AXI master channels
// ============================================================================
`default_nettype none

module l1c_axi_bridge (
  input  logic        clk,
  input  logic        rstn,
  input  logic        D_req,
  input  logic [31:0] D_addr,
  input  logic        D_write,
  input  logic [31:0] D_in,
  input  logic [3:0]  D_type,
  output logic [31:0] D_out,
  output logic        rvalid_o,
  output logic        rready_o,
  output logic        wdone_o,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [31:0] AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic        BVALID,
  output logic        BREADY
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [27:0] r_araddr_hi;   // line-aligned, low nibble is always zero
  logic [3:0]  r_arlen;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_aw_pend;     // AW handshake still outstanding
  logic        r_w_pend;      // W handshake still outstanding
  logic [1:0]  r_beat_cnt;
  logic        w_aw_done;
  logic        w_w_done;

  // A channel counts as done if it already handshook or handshakes now.
  assign w_aw_done = ~r_aw_pend | AWREADY;
  assign w_w_done  = ~r_w_pend  | WREADY;

  assign ARADDR  = {r_araddr_hi, 4'h0};
  assign ARLEN   = r_arlen;
  assign AWADDR  = r_awaddr;
  assign WDATA   = r_wdata;
  assign WSTRB   = r_wstrb;
  assign WLAST   = 1'b1;
  assign AWVALID = r_aw_pend;
  assign WVALID  = r_w_pend;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    ARVALID  = 1'b0;
    RREADY   = 1'b0;
    BREADY   = 1'b0;
    rvalid_o = 1'b0;
    rready_o = 1'b0;
    wdone_o  = 1'b0;
    D_out    = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (D_req) w_next = D_write ? S_WR : S_AR;
      end
      S_AR: begin
        ARVALID = 1'b1;
        if (ARREADY) w_next = S_RD;
      end
      S_RD: begin
        // Zero-latency pass-through of the R channel to the cache.
        RREADY   = 1'b1;
        rready_o = 1'b1;
        rvalid_o = RVALID;
        D_out    = RDATA;
        if (RVALID && RLAST) w_next = S_DONE;
      end
      S_WR: begin
        if (w_aw_done && w_w_done) w_next = S_RESP;
      end
      S_RESP: begin
        BREADY  = 1'b1;
        wdone_o = BVALID;
        if (BVALID) w_next = S_DONE;
      end
      // One dead cycle so a D_req still held high cannot re-issue.
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_araddr_hi <= 28'd0;
      r_arlen     <= 4'd0;
      r_awaddr    <= 32'd0;
      r_wdata     <= 32'd0;
      r_wstrb     <= 4'd0;
      r_aw_pend   <= 1'b0;
      r_w_pend    <= 1'b0;
      r_beat_cnt  <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_beat_cnt <= 2'd0;
          if (D_req && !D_write) begin
            r_araddr_hi <= D_addr[31:4];
            r_arlen     <= 4'd3;
          end
          if (D_req && D_write) begin
            r_awaddr  <= D_addr;
            r_wdata   <= D_in;
            r_wstrb   <= ~D_type;
            r_aw_pend <= 1'b1;
            r_w_pend  <= 1'b1;
          end
        end
        S_RD: begin
          if (RVALID) r_beat_cnt <= r_beat_cnt + 2'd1;
        end
        S_WR: begin
          if (AWREADY) r_aw_pend <= 1'b0;
          if (WREADY)  r_w_pend  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // RLAST must coincide with the fourth beat; exit still follows RLAST.
  always_ff @(posedge clk) begin
    if (rstn && r_state == S_RD && RVALID && RLAST)
      assert (r_beat_cnt == 2'd3);
  end

endmodule

`default_nettype wire
